nibble_serial_adder: RTL
========================

# nibble_serial_adder

Sequential WIDTH-bit adder/subtractor that drives a 4-bit carry-lookahead slice, processing one nibble per clock from LSB to MSB. A registered carry links successive nibbles. It sits directly upstream of the CLA_4_bit stage: it sequences operand nibbles and carry into the slice and collects the sum and carry it produces. It gives the datapath wide add/sub with one 4-bit CLA instead of WIDTH/4 parallel slices.

## Interface
- WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 8. N = WIDTH/4 nibbles.
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when busy = 0.
- a  input  WIDTH  operand A; captured on an accepted start.
- b  input  WIDTH  operand B; captured on an accepted start.
- cin  input  1  carry-in for add; ignored when sub = 1.
- sub  input  1  0 = A+B+cin; 1 = A−B, computed as A + ~B + 1.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse: sum, cout and ovf are valid.
- sum  output  WIDTH  result register.
- cout  output  1  carry out of bit WIDTH−1. When sub = 1 this is the not-borrow flag (1 when A ≥ B unsigned).
- ovf  output  1  two's-complement signed overflow.

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: busy 0, done 0, sum 0, cout 0, ovf 0; internal registers (operands, carry, index) are all 0.
- IDLE or DONE, start = 1:
  - Capture a into the A shift register.
  - Capture b XOR {WIDTH{sub}} into the B shift register.
  - Load the carry register with (sub ? 1 : cin).
  - Load the MSB sign bits.
  - Set idx = 0 and go to RUN.
- DONE, start = 0: go to IDLE.
- RUN, each cycle:
  - The CLA slice takes A_sr[3:0], B_sr[3:0] and the carry register.
  - The slice's s is shifted into the top of the result shift register.
  - The carry register takes the slice's cout.
  - A_sr and B_sr shift right by 4.
  - idx increments.
- RUN, when idx = N−1 on that edge:
  - Load sum with the final assembled result.
  - Load cout with the slice's cout.
  - Load ovf with (a_msb == beff_msb) && (result_msb != a_msb), where beff is the inverted B when sub = 1.
  - Go to DONE.
- busy = 1 exactly in RUN. done = 1 exactly in DONE.
- sum, cout and ovf change only on the final RUN edge. They hold until the next operation's final edge, so they stay stable through the next RUN.
- start while busy = 1 is ignored. It is not queued.
- Changing a, b, cin or sub after capture has no effect on the operation in progress.
- Arithmetic is modulo 2^WIDTH. The carry out of each nibble feeds the next nibble only; nothing wraps from the MSB back to the LSB.

## Timing
- Latency: start sampled at edge t0 means nibble k is processed at edge t(k+1). sum, cout, ovf and done are valid after edge tN.
- With WIDTH = 16, done is high in the cycle between t4 and t5.
- Back-to-back operation: start sampled high at the DONE edge is accepted, and RUN resumes at the next edge. Throughput is one result per N+1 cycles.
- The same-edge start in DONE wins over the DONE→IDLE transition.
- Reset mid-operation: rst_n low forces IDLE and all reset values immediately, with no clock required. The partial result is discarded.
- Reset release takes effect at the first rising clk edge after rst_n goes high. start is not honoured on that same edge if it coincides with deassertion; the synchroniser is the upstream block's responsibility.

## Test plan
- Plain add: WIDTH = 16, a = 0x1234, b = 0x4321, cin = 0, sub = 0, start pulse. Required: busy high for 4 cycles, then done for 1 cycle, with sum = 0x5555, cout = 0, ovf = 0.
- Full carry ripple: a = 0xFFFF, b = 0x0001, cin = 0. Required: sum = 0x0000, cout = 1, ovf = 0. Repeat with a = 0xFFFF, b = 0x0000, cin = 1 and get the same result.
- Signed overflow: a = 0x7FFF, b = 0x0001 add gives sum = 0x8000, cout = 0, ovf = 1. Subtract a = 0x8000, sub b = 0x0001 gives sum = 0x7FFF, cout = 1, ovf = 1.
- Subtract with borrow: a = 0x0005, b = 0x0007, sub = 1, cin = 1 (must be ignored). Required: sum = 0xFFFE, cout = 0, ovf = 0.
- Handshake:
  - A second start with new operands during cycles 2–3 of RUN is ignored; the result is from the first operands only.
  - A start asserted in the DONE cycle is accepted: the next done comes exactly 5 cycles after the previous done.
  - sum holds the previous value throughout the second RUN.
- Mid-operation reset: rst_n pulled low at RUN idx = 2. Required: busy, done, sum, cout and ovf go to 0 immediately. After release, a new start (0x0001 + 0x0001) produces sum = 0x0002 with normal latency.

Source files
------------

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//
// Sequential WIDTH-bit adder/subtractor built around one 4-bit carry-lookahead
// slice. One nibble is processed per clock, LSB first. A registered carry links
// successive nibbles. Subtraction is computed as A + ~B + 1.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   start  - operation request, sampled only while not busy
//   a, b   - operands, captured on an accepted start
//   cin    - carry-in for add (ignored when sub = 1)
//   sub    - 0: A+B+cin, 1: A-B
//   busy   - high while nibbles are being processed
//   done   - one-cycle pulse; sum/cout/ovf valid
//   sum    - result register
//   cout   - carry out of the MSB (not-borrow when sub = 1)
//   ovf    - two's-complement signed overflow
module nibble_serial_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned N    = WIDTH / 4;
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(N - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_sr_q, res_sr_d;
  logic             carry_q, carry_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             a_msb_q, a_msb_d;
  logic             beff_msb_q, beff_msb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  // 4-bit carry-lookahead slice on the low nibble of the operand shifters.
  logic [3:0] cla_g, cla_p, cla_s;
  logic [4:0] cla_c;

  always_comb begin
    cla_g    = a_sr_q[3:0] & b_sr_q[3:0];
    cla_p    = a_sr_q[3:0] ^ b_sr_q[3:0];
    cla_c[0] = carry_q;
    cla_c[1] = cla_g[0] | (cla_p[0] & cla_c[0]);
    cla_c[2] = cla_g[1] | (cla_p[1] & cla_g[0]) | (cla_p[1] & cla_p[0] & cla_c[0]);
    cla_c[3] = cla_g[2] | (cla_p[2] & cla_g[1]) | (cla_p[2] & cla_p[1] & cla_g[0])
             | (cla_p[2] & cla_p[1] & cla_p[0] & cla_c[0]);
    cla_c[4] = cla_g[3] | (cla_p[3] & cla_g[2]) | (cla_p[3] & cla_p[2] & cla_g[1])
             | (cla_p[3] & cla_p[2] & cla_p[1] & cla_g[0])
             | (cla_p[3] & cla_p[2] & cla_p[1] & cla_p[0] & cla_c[0]);
    cla_s    = cla_p ^ cla_c[3:0];
  end

  always_comb begin
    state_d    = state_q;
    a_sr_d     = a_sr_q;
    b_sr_d     = b_sr_q;
    res_sr_d   = res_sr_q;
    carry_d    = carry_q;
    idx_d      = idx_q;
    a_msb_d    = a_msb_q;
    beff_msb_d = beff_msb_q;
    sum_d      = sum_q;
    cout_d     = cout_q;
    ovf_d      = ovf_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          a_sr_d     = a;
          b_sr_d     = b ^ {WIDTH{sub}};
          carry_d    = sub ? 1'b1 : cin;
          a_msb_d    = a[WIDTH-1];
          beff_msb_d = b[WIDTH-1] ^ sub;
          idx_d      = '0;
          state_d    = StRun;
        end else if (state_q == StDone) begin
          state_d = StIdle;
        end
      end
      StRun: begin
        // Slice sum enters at the top; after N shifts nibble 0 sits at the bottom.
        res_sr_d = {cla_s, res_sr_q[WIDTH-1:4]};
        carry_d  = cla_c[4];
        a_sr_d   = {4'b0000, a_sr_q[WIDTH-1:4]};
        b_sr_d   = {4'b0000, b_sr_q[WIDTH-1:4]};
        idx_d    = idx_q + 1'b1;
        if (idx_q == IdxLast) begin
          sum_d   = {cla_s, res_sr_q[WIDTH-1:4]};
          cout_d  = cla_c[4];
          ovf_d   = (a_msb_q == beff_msb_q) && (cla_s[3] != a_msb_q);
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      a_sr_q     <= '0;
      b_sr_q     <= '0;
      res_sr_q   <= '0;
      carry_q    <= 1'b0;
      idx_q      <= '0;
      a_msb_q    <= 1'b0;
      beff_msb_q <= 1'b0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_sr_q     <= a_sr_d;
      b_sr_q     <= b_sr_d;
      res_sr_q   <= res_sr_d;
      carry_q    <= carry_d;
      idx_q      <= idx_d;
      a_msb_q    <= a_msb_d;
      beff_msb_q <= beff_msb_d;
      sum_q      <= sum_d;
      cout_q     <= cout_d;
      ovf_q      <= ovf_d;
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
